// File: rtl/audio_pkg.sv
// audio_pkg: shared sample/slot widths, transmitter FSM states and mixer-to-two's-complement conversion.
package audio_pkg;
    localparam int SAMPLE_W = 24;
    localparam int SLOT_W = 32;
    localparam int FRAME_W = 64;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} tx_state_t;

    // Mixer negatives are ~magnitude; adding one maps them onto two's complement (-0 becomes 0).
    function automatic logic [SAMPLE_W-1:0] ones_to_twos(input logic [SAMPLE_W-1:0] s);
        return s[SAMPLE_W-1] ? s + SAMPLE_W'(1) : s;
    endfunction
endpackage

// File: rtl/i2s_bclk_gen.sv
// i2s_bclk_gen: divides clk into BCLK (BCLK_DIV clk per half-period) and flags the cycle before each fall.
module i2s_bclk_gen #(
    parameter int BCLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic bclk_o,
    output logic fall_o
);
    localparam int CW = BCLK_DIV > 1 ? $clog2(BCLK_DIV) : 1;

    logic [CW-1:0] div_q, div_d;
    logic bclk_q, bclk_d, wrap;

    always_comb begin
        wrap = div_q == CW'(BCLK_DIV - 1);
        div_d = !en_i || wrap ? '0 : div_q + CW'(1);
        bclk_d = en_i && (wrap ? !bclk_q : bclk_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
            bclk_q <= 1'b0;
        end else begin
            div_q <= div_d;
            bclk_q <= bclk_d;
        end
    end

    assign bclk_o = bclk_q;
    assign fall_o = en_i && wrap && bclk_q;
endmodule

// File: rtl/i2s_stereo_tx.sv
// i2s_stereo_tx: I2S bus-master transmitter for 24-bit stereo mixer samples with a one-entry holding register.
// Define I2S_TX_LEFT_JUSTIFIED_EN for left-justified slots instead of one-BCLK-delayed I2S data.
module i2s_stereo_tx
    import audio_pkg::*;
#(
    parameter int BCLK_DIV = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [SAMPLE_W-1:0] left_in,
    input  logic [SAMPLE_W-1:0] right_in,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                bclk,
    output logic                lrclk,
    output logic                sdata,
    output logic                underrun,
    output logic                frame_start
);
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
    localparam logic [4:0] LEAD = 5'd0;
`else
    localparam logic [4:0] LEAD = 5'd1;
`endif

    tx_state_t state_q, state_d;
    logic active_q, active_d, ready_q, ready_d, sdata_q, sdata_d;
    logic under_q, under_d, fs_q, fs_d;
    logic [5:0] bit_q, bit_d;
    logic [2*SAMPLE_W-1:0] hold_q, hold_d, shadow_q, shadow_d;
    logic fall, load, last_bit, drain_stop;
    logic [4:0] pos;
    logic [SAMPLE_W-1:0] word;

    i2s_bclk_gen #(.BCLK_DIV(BCLK_DIV)) u_bclk (
        .clk   (clk),
        .rst   (rst),
        .en_i  (state_q != IDLE),
        .bclk_o(bclk),
        .fall_o(fall)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        last_bit = fall && bit_q == 6'd63;
        drain_stop = state_q == DRAIN && !enable;
        state_d = enable ? RUN
                : state_q == RUN ? DRAIN
                : state_q == DRAIN && active_q && !last_bit ? DRAIN : IDLE;
    end

    // active_q marks that the first frame load has happened since leaving IDLE.
    always_comb begin
        load = fall && (!active_q || bit_q == 6'd63) && !drain_stop;
        active_d = state_d != IDLE && (active_q || load);
        bit_d = state_d == IDLE ? 6'd0 : fall ? (active_q ? bit_q + 6'd1 : 6'd0) : bit_q;
        shadow_d = !load ? shadow_q
                 : ready_q ? '0
                 : {ones_to_twos(hold_q[2*SAMPLE_W-1:SAMPLE_W]), ones_to_twos(hold_q[SAMPLE_W-1:0])};
        hold_d = in_valid && ready_q ? {left_in, right_in} : hold_q;
        ready_d = in_valid && ready_q ? 1'b0 : load ? 1'b1 : ready_q;
        under_d = load && ready_q;
        fs_d = load;
        pos = bit_d[4:0] - LEAD;
        word = bit_d[5] ? shadow_d[SAMPLE_W-1:0] : shadow_d[2*SAMPLE_W-1:SAMPLE_W];
        sdata_d = state_d == IDLE ? 1'b0
                : fall ? active_d && pos < 5'd24 && word[5'd23 - pos] : sdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            ready_q <= 1'b1;
            sdata_q <= 1'b0;
            under_q <= 1'b0;
            fs_q <= 1'b0;
            bit_q <= 6'd0;
            hold_q <= '0;
            shadow_q <= '0;
        end else begin
            active_q <= active_d;
            ready_q <= ready_d;
            sdata_q <= sdata_d;
            under_q <= under_d;
            fs_q <= fs_d;
            bit_q <= bit_d;
            hold_q <= hold_d;
            shadow_q <= shadow_d;
        end
    end

    assign in_ready = ready_q;
    assign lrclk = bit_q[5];
    assign sdata = sdata_q;
    assign underrun = under_q;
    assign frame_start = fs_q;
endmodule

// File: tb/tb_i2s_stereo_tx.sv
// tb_i2s_stereo_tx: scoreboard bench for i2s_stereo_tx at BCLK_DIV=2 (one frame = 256 clk).
module tb_i2s_stereo_tx;
    localparam int DIV = 2;
    localparam int FRAME = 128 * DIV;

    typedef struct packed {
        logic        lr_ok;
        logic [31:0] bits;
    } slot_t;

    logic clk = 1'b0, rst = 1'b1, enable = 1'b0, in_valid = 1'b0;
    logic [23:0] left_in = '0, right_in = '0;
    logic in_ready, bclk, lrclk, sdata, underrun, frame_start;
    int checks = 0, failures = 0;
    slot_t got_q[$];
    logic [23:0] exp_q[$];
    int bitn = -1, lr_bad = 0;
    logic pb = 1'b0;
    logic [31:0] sh = '0;

    i2s_stereo_tx #(.BCLK_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .enable(enable), .left_in(left_in), .right_in(right_in),
        .in_valid(in_valid), .in_ready(in_ready), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
        .underrun(underrun), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] wire_slot(input logic [23:0] w);
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
        return {w, 8'h00};
`else
        return {1'b0, w, 7'h00};
`endif
    endfunction

    // Collects each slot as captured on BCLK rising edges, starting at frame_start.
    always @(negedge clk) begin
        pb <= bclk;
        if (rst) bitn <= -1;
        else if (frame_start) begin
            bitn <= 0;
            lr_bad <= 0;
        end else if (bclk && !pb && bitn >= 0) begin
            sh <= {sh[30:0], sdata};
            if (bitn == 31 || bitn == 63) begin
                got_q.push_back(slot_t'({lr_bad == 0 && lrclk == (bitn >= 32), sh[30:0], sdata}));
                lr_bad <= 0;
            end else lr_bad <= lr_bad + int'(lrclk != (bitn >= 32));
            bitn <= bitn == 63 ? -1 : bitn + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; in_valid = 1'b0;
        tick(4);
        rst = 1'b0;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic push(input logic [23:0] l, r, el, er, output bit to);
        int n = 0;
        in_valid = 1'b1; left_in = l; right_in = r;
        while (!in_ready && n < 2 * FRAME) begin tick(1); n++; end
        to = !in_ready;
        tick(1);
        in_valid = 1'b0;
        if (!to) begin exp_q.push_back(el); exp_q.push_back(er); end
    endtask

    task automatic wait_fs(output bit to);
        int n = 0;
        while (!frame_start && n < 4 * FRAME) begin tick(1); n++; end
        to = !frame_start;
    endtask

    task automatic get_slot(output slot_t s, output bit to);
        int n = 0;
        while (got_q.size() == 0 && n < 4 * FRAME) begin tick(1); n++; end
        to = got_q.size() == 0;
        s = to ? '0 : got_q.pop_front();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({bclk, lrclk, sdata, underrun, frame_start} !== 5'b0) begin
            failures++; $display("FAIL reset_lines got=%b exp=00000", {bclk, lrclk, sdata, underrun, frame_start});
        end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_basic_frame();
        slot_t s; bit to; logic [23:0] e;
        do_reset();
        push(24'h400001, 24'h7FFFFF, 24'h400001, 24'h7FFFFF, to);
        checks++;
        if (to) begin failures++; $display("FAIL basic_push got=timeout exp=accepted"); end
        enable = 1'b1;
        wait_fs(to);
        checks++;
        if (to || underrun !== 1'b0) begin failures++; $display("FAIL basic_load timeout=%b underrun=%b exp=0", to, underrun); end
        tick(1);
        checks++;
        if (frame_start !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL basic_pulse frame_start=%b in_ready=%b exp=0/1", frame_start, in_ready);
        end
        while (exp_q.size() > 0) begin
            get_slot(s, to); e = exp_q.pop_front(); checks++;
            if (to || !s.lr_ok || s.bits !== wire_slot(e)) begin
                failures++; $display("FAIL basic_slot got=%h lr_ok=%b timeout=%b exp=%h", s.bits, s.lr_ok, to, wire_slot(e));
            end
        end
    endtask

    task automatic test_conversion();
        slot_t s; bit to, to2; logic [23:0] e;
        do_reset();
        push(24'hFFFFFE, 24'hFFFFFF, 24'hFFFFFF, 24'h000000, to);
        enable = 1'b1;
        push(24'h800000, 24'h000005, 24'h800001, 24'h000005, to2);
        checks++;
        if (to || to2) begin failures++; $display("FAIL conv_push timeouts=%b%b exp=00", to, to2); end
        while (exp_q.size() > 0) begin
            get_slot(s, to); e = exp_q.pop_front(); checks++;
            if (to || !s.lr_ok || s.bits !== wire_slot(e)) begin
                failures++; $display("FAIL conv_slot got=%h lr_ok=%b timeout=%b exp=%h", s.bits, s.lr_ok, to, wire_slot(e));
            end
        end
    endtask

    task automatic test_underrun();
        slot_t s; bit to; logic [23:0] e;
        do_reset();
        enable = 1'b1;
        for (int f = 0; f < 2; f++) begin
            wait_fs(to);
            checks++;
            if (to || underrun !== 1'b1 || in_ready !== 1'b1) begin
                failures++; $display("FAIL underrun_load%0d timeout=%b underrun=%b in_ready=%b exp=1/1", f, to, underrun, in_ready);
            end
            tick(1);
            checks++;
            if (underrun !== 1'b0 || frame_start !== 1'b0) begin
                failures++; $display("FAIL underrun_pulse%0d underrun=%b frame_start=%b exp=0/0", f, underrun, frame_start);
            end
            exp_q.push_back(24'h0); exp_q.push_back(24'h0);
        end
        while (exp_q.size() > 0) begin
            get_slot(s, to); e = exp_q.pop_front(); checks++;
            if (to || !s.lr_ok || s.bits !== wire_slot(e)) begin
                failures++; $display("FAIL underrun_slot got=%h lr_ok=%b timeout=%b exp=%h", s.bits, s.lr_ok, to, wire_slot(e));
            end
        end
    endtask

    task automatic test_backpressure();
        slot_t s; bit to; logic [23:0] e; int n = 0;
        do_reset();
        enable = 1'b1;
        wait_fs(to);
        exp_q.push_back(24'h0); exp_q.push_back(24'h0);
        tick(40);
        push(24'h0A0B0C, 24'h8F0000, 24'h0A0B0C, 24'h8F0001, to);
        checks++;
        if (to || in_ready !== 1'b0) begin failures++; $display("FAIL bp_first timeout=%b in_ready=%b exp=0", to, in_ready); end
        in_valid = 1'b1; left_in = 24'h123456; right_in = 24'hFFFF00;
        while (!in_ready && n < 2 * FRAME) begin tick(1); n++; end
        checks++;
        if (in_ready !== 1'b1 || frame_start !== 1'b1) begin
            failures++; $display("FAIL bp_release in_ready=%b frame_start=%b exp=1/1", in_ready, frame_start);
        end
        tick(1);
        in_valid = 1'b0;
        exp_q.push_back(24'h123456); exp_q.push_back(24'hFFFF01);
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_second in_ready=%b exp=0", in_ready); end
        while (exp_q.size() > 0) begin
            get_slot(s, to); e = exp_q.pop_front(); checks++;
            if (to || !s.lr_ok || s.bits !== wire_slot(e)) begin
                failures++; $display("FAIL bp_slot got=%h lr_ok=%b timeout=%b exp=%h", s.bits, s.lr_ok, to, wire_slot(e));
            end
        end
    endtask

    task automatic test_stop();
        slot_t s; bit to; logic [23:0] e; int bad = 0;
        do_reset();
        push(24'h3C3C3C, 24'hC3C3C3, 24'h3C3C3C, 24'hC3C3C4, to);
        enable = 1'b1;
        wait_fs(to);
        tick(10 * 2 * DIV);
        enable = 1'b0;
        tick(FRAME - 10 * 2 * DIV + 4);
        for (int i = 0; i < 300; i++) begin
            bad += int'(bclk | lrclk | sdata | frame_start);
            tick(1);
        end
        checks++;
        if (to || bad != 0) begin failures++; $display("FAIL stop_idle timeout=%b active_cycles=%0d exp=0", to, bad); end
        while (exp_q.size() > 0) begin
            get_slot(s, to); e = exp_q.pop_front(); checks++;
            if (to || !s.lr_ok || s.bits !== wire_slot(e)) begin
                failures++; $display("FAIL stop_slot got=%h lr_ok=%b timeout=%b exp=%h", s.bits, s.lr_ok, to, wire_slot(e));
            end
        end
        checks++;
        if (got_q.size() != 0) begin failures++; $display("FAIL stop_extra slots=%0d exp=0", got_q.size()); end
    endtask

    task automatic test_drain_reenable();
        slot_t s; bit to, to2; logic [23:0] e; time t0;
        do_reset();
        push(24'h000001, 24'h7FFFFE, 24'h000001, 24'h7FFFFE, to);
        enable = 1'b1;
        wait_fs(to);
        t0 = $time;
        tick(40);
        enable = 1'b0;
        push(24'h555555, 24'hAAAAAA, 24'h555555, 24'hAAAAAB, to2);
        tick(40);
        enable = 1'b1;
        wait_fs(to);
        checks++;
        if (to || to2 || $time - t0 != FRAME * 10) begin
            failures++; $display("FAIL drain_gap frame_period=%0t timeout=%b%b exp=%0d", $time - t0, to, to2, FRAME * 10);
        end
        while (exp_q.size() > 0) begin
            get_slot(s, to); e = exp_q.pop_front(); checks++;
            if (to || !s.lr_ok || s.bits !== wire_slot(e)) begin
                failures++; $display("FAIL drain_slot got=%h lr_ok=%b timeout=%b exp=%h", s.bits, s.lr_ok, to, wire_slot(e));
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        slot_t s; bit to; logic [23:0] e;
        do_reset();
        push(24'h654321, 24'h100000, 24'h654321, 24'h100000, to);
        enable = 1'b1;
        wait_fs(to);
        tick(1);
        push(24'h111111, 24'h222222, 24'h111111, 24'h222222, to);
        tick(37 * 2 * DIV - 2);
        get_slot(s, to); e = exp_q.pop_front(); checks++;
        if (to || !s.lr_ok || s.bits !== wire_slot(e)) begin
            failures++; $display("FAIL rstmid_left got=%h lr_ok=%b timeout=%b exp=%h", s.bits, s.lr_ok, to, wire_slot(e));
        end
        rst = 1'b1;
        tick(1);
        checks++;
        if ({bclk, lrclk, sdata, in_ready} !== 4'b0001) begin
            failures++; $display("FAIL rstmid_lines got=%b exp=0001", {bclk, lrclk, sdata, in_ready});
        end
        do_reset();
        enable = 1'b1;
        wait_fs(to);
        checks++;
        if (to || underrun !== 1'b1) begin failures++; $display("FAIL rstmid_discard timeout=%b underrun=%b exp=1", to, underrun); end
        exp_q.push_back(24'h0); exp_q.push_back(24'h0);
        while (exp_q.size() > 0) begin
            get_slot(s, to); e = exp_q.pop_front(); checks++;
            if (to || !s.lr_ok || s.bits !== wire_slot(e)) begin
                failures++; $display("FAIL rstmid_slot got=%h lr_ok=%b timeout=%b exp=%h", s.bits, s.lr_ok, to, wire_slot(e));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_conversion();
        test_underrun();
        test_backpressure();
        test_stop();
        test_drain_reenable();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
